// File: rtl/core_bus_port.sv
// core_bus_port: per-core memory port between a MIPS core's data-memory
// interface and one request/grant slot of the dual-core bus arbiter.
// The core's access is latched, a request is raised, and the core is stalled
// until the arbiter has carried out the access. Read data is captured only
// after READ_LAT consecutive grant cycles in WAIT.
// Optional feature macro: BUS_PORT_TIMEOUT_EN (wait-cycle watchdog with a
// sticky bus_timeout flag; when undefined the port waits indefinitely).
module core_bus_port #(
    parameter int READ_LAT = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_memread,
    input  logic        core_memwrite,
    input  logic [15:0] core_addr,
    input  logic [7:0]  core_writedata,
    output logic [7:0]  core_readdata,
    output logic        stall,
    output logic        request,
    output logic        memread,
    output logic        memwrite,
    output logic [15:0] addr,
    output logic [7:0]  writedata,
    input  logic        grant,
    input  logic [7:0]  readdata,
    output logic        bus_timeout
);

    localparam int CNT_MAX = (READ_LAT > TIMEOUT) ? READ_LAT : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               access_strobe;
    logic               latch_en;
    logic               capture_en;
    logic               timeout_hit;

    assign access_strobe = core_memread | core_memwrite;

`ifdef BUS_PORT_TIMEOUT_EN
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_flag;
    logic               wait_expired;

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign bus_timeout  = timeout_flag;
`else
    assign bus_timeout  = 1'b0;
`endif

    // State register; reset abandons whatever access was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the combinational stall/request handshake.
    always_comb begin
        state_next  = state;
        request     = 1'b0;
        stall       = 1'b0;
        latch_en    = 1'b0;
        capture_en  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                stall = access_strobe;
                if (access_strobe) begin
                    latch_en   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall   = 1'b1;
                // A granted write is issued once; dropping request now stops a repeat.
                request = !(grant && memwrite);
                if (grant) begin
                    state_next = memwrite ? RESP : WAIT;
                end
            end
            WAIT: begin
                stall   = 1'b1;
                request = 1'b1;
                if (grant && (cnt == CNT_W'(READ_LAT))) begin
                    capture_en = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef BUS_PORT_TIMEOUT_EN
        // Normal completion in the same cycle takes precedence over the watchdog.
        if (((state == REQ) || (state == WAIT)) && wait_expired && (state_next != RESP)) begin
            timeout_hit = 1'b1;
            state_next  = RESP;
        end
`endif
    end

    // Bus-side operation registers, grant counter and core read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            memread       <= 1'b0;
            memwrite      <= 1'b0;
            addr          <= '0;
            writedata     <= '0;
            core_readdata <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (latch_en) begin
                        addr      <= core_addr;
                        writedata <= core_writedata;
                        memwrite  <= core_memwrite;
                        memread   <= core_memread & ~core_memwrite;
                        cnt       <= '0;
                    end
                end
                REQ: begin
                    if (grant && memread) begin
                        cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    // Only an unbroken run of grants counts, so captured data is ours.
                    if (!grant) begin
                        cnt <= '0;
                    end else if (!capture_en) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    memread  <= 1'b0;
                    memwrite <= 1'b0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
            if (capture_en) begin
                core_readdata <= readdata;
            end else if (timeout_hit && memread) begin
                core_readdata <= 8'hFF;
            end
        end
    end

`ifdef BUS_PORT_TIMEOUT_EN
    // Watchdog: counts REQ/WAIT cycles of the current access; flag is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (latch_en) begin
                wait_cnt <= '0;
            end else if ((state == REQ) || (state == WAIT)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`endif

endmodule
